// File: rtl/mult8_seq_ctrl.sv
// mult8_seq_ctrl: 8x8 sequential multiplier controller, 4x4 partial product per step driven by an external 2-bit counter.
// Optional step-sequence checking via `define MULT_SEQ_CHECK_EN.
module mult8_seq_ctrl (
  input  logic        clk,
  input  logic        aclr_n,
  input  logic        start,
  input  logic [7:0]  dataa,
  input  logic [7:0]  datab,
  input  logic [1:0]  count_in,
  output logic        cnt_clr_n,
  output logic [15:0] product,
  output logic        done,
  output logic        busy,
  output logic        seq_err
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  state_t state;
  logic [7:0] a_r, b_r, pp;
  logic [3:0] pa, pb;
  logic [15:0] acc, term;
  logic last;
  assign pa = count_in[1] ? a_r[7:4] : a_r[3:0];
  assign pb = count_in[0] ? b_r[7:4] : b_r[3:0];
  assign pp = {4'd0, pa} * {4'd0, pb};
  assign term = count_in == 2'd0 ? {8'd0, pp} : count_in == 2'd3 ? {pp, 8'd0} : {4'd0, pp, 4'd0};
`ifdef MULT_SEQ_CHECK_EN
  logic [1:0] shadow;
  // The shadow step also bounds RUN so a stuck counter cannot hang the block.
  assign last = count_in == 2'd3 || shadow == 2'd3;
  always_ff @(posedge clk or negedge aclr_n)
    if (!aclr_n) begin
      shadow <= 2'd0;
      seq_err <= 1'b0;
    end else if (state == IDLE && start) seq_err <= 1'b0;
    else if (state == LOAD) shadow <= 2'd0;
    else if (state == RUN) begin
      shadow <= shadow + 2'd1;
      if (count_in != shadow) seq_err <= 1'b1;
    end
`else
  assign last = count_in == 2'd3;
  assign seq_err = 1'b0;
`endif
  always_ff @(posedge clk or negedge aclr_n)
    if (!aclr_n) begin
      state <= IDLE;
      a_r <= 8'd0;
      b_r <= 8'd0;
      acc <= 16'd0;
      product <= 16'd0;
      done <= 1'b0;
      busy <= 1'b0;
      cnt_clr_n <= 1'b0;
    end else begin
      done <= 1'b0;
      cnt_clr_n <= 1'b1;
      case (state)
        IDLE: if (start) begin
          a_r <= dataa;
          b_r <= datab;
          busy <= 1'b1;
          cnt_clr_n <= 1'b0;
          state <= LOAD;
        end
        LOAD: begin
          acc <= 16'd0;
          state <= RUN;
        end
        RUN: begin
          acc <= acc + term;
          if (last) begin
            product <= acc + term;
            done <= 1'b1;
            busy <= 1'b0;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mult8_seq_ctrl.sv
// tb_mult8_seq_ctrl: directed bench for mult8_seq_ctrl with a modelled 2-bit step counter.
module tb_mult8_seq_ctrl;
  logic clk = 1'b0, aclr_n = 1'b0, start = 1'b0, stuck = 1'b0;
  logic [7:0] dataa = 8'd0, datab = 8'd0;
  logic [1:0] cnt, count_in;
  logic cnt_clr_n, done, busy, seq_err, clr;
  logic [15:0] product;
  int total = 0, bad = 0;
  int lat, busy_n, done_n;
  logic chg, err_seen;
  always #5 clk = ~clk;
  assign clr = aclr_n & cnt_clr_n;
  assign count_in = stuck ? 2'd1 : cnt;
  always_ff @(posedge clk or negedge clr)
    if (!clr) cnt <= 2'd0;
    else cnt <= cnt + 2'd1;
  mult8_seq_ctrl dut (
    .clk(clk), .aclr_n(aclr_n), .start(start), .dataa(dataa), .datab(datab),
    .count_in(count_in), .cnt_clr_n(cnt_clr_n), .product(product),
    .done(done), .busy(busy), .seq_err(seq_err)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // Called at a negedge; start is dropped at the negedge numbered hold_k after the start edge.
  task automatic op(input logic [7:0] a, input logic [7:0] b, input int hold_k,
                    output int l, output int bn, output int dn, output logic c, output logic es);
    logic [15:0] prev;
    prev = product;
    l = -1; bn = 0; dn = 0; c = 1'b0; es = 1'b0;
    dataa = a; datab = b; start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == hold_k) start = 1'b0;
      bn += int'(busy);
      dn += int'(done);
      es |= seq_err;
      if (done && l < 0) l = k;
      if (k < 5 && product !== prev) c = 1'b1;
    end
  endtask
  initial begin
    @(negedge clk);
    #1;
    chk("rst_product", product, 16'h0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_clr", cnt_clr_n, 0);
    chk("rst_err", seq_err, 0);
    @(negedge clk);
    aclr_n = 1'b1;
    #1 chk("rel_clr_low", cnt_clr_n, 0);
    @(negedge clk);
    chk("rel_clr_high", cnt_clr_n, 1);
    op(8'hFF, 8'hFF, 0, lat, busy_n, done_n, chg, err_seen);
    chk("ff_lat", lat, 5);
    chk("ff_busy", busy_n, 5);
    chk("ff_done_n", done_n, 1);
    chk("ff_prod", product, 16'hFE01);
    chk("ff_hold", chg, 0);
    op(8'd12, 8'd10, 0, lat, busy_n, done_n, chg, err_seen);
    chk("c_prod", product, 16'h0078);
    chk("c_hold", chg, 0);
    chk("c_lat", lat, 5);
    op(8'd0, 8'hA5, 0, lat, busy_n, done_n, chg, err_seen);
    chk("z_prod", product, 16'h0000);
    repeat (3) @(negedge clk);
    chk("z_stable", product, 16'h0000);
    op(8'h13, 8'h11, 6, lat, busy_n, done_n, chg, err_seen);
    chk("ign_done_n", done_n, 1);
    chk("ign_lat", lat, 5);
    chk("ign_prod", product, 16'h0143);
    chk("ign_idle", busy, 0);
    dataa = 8'd200; datab = 8'd150; start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    aclr_n = 1'b0;
    #1;
    chk("ar_product", product, 16'h0);
    chk("ar_busy", busy, 0);
    chk("ar_done", done, 0);
    chk("ar_clr", cnt_clr_n, 0);
    chk("ar_err", seq_err, 0);
    @(negedge clk);
    aclr_n = 1'b1;
    @(negedge clk);
    op(8'd200, 8'd150, 0, lat, busy_n, done_n, chg, err_seen);
    chk("ar2_prod", product, 16'h7530);
    chk("ar2_lat", lat, 5);
`ifdef MULT_SEQ_CHECK_EN
    stuck = 1'b1;
    op(8'h12, 8'h34, 0, lat, busy_n, done_n, chg, err_seen);
    stuck = 1'b0;
    chk("stk_lat", lat, 5);
    chk("stk_err", seq_err, 1);
    chk("stk_prod", product, 16'h0180);
    op(8'h12, 8'h34, 0, lat, busy_n, done_n, chg, err_seen);
    chk("stk_clear", seq_err, 0);
    chk("stk2_prod", product, 16'h03A8);
`else
    op(8'h12, 8'h34, 0, lat, busy_n, done_n, chg, err_seen);
    chk("noerr_seen", err_seen, 0);
    chk("noerr_prod", product, 16'h03A8);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
